// File: rtl/vend_countdown.sv
// vend_countdown: transaction countdown timer driven by free-running 1 Hz / 2 Hz
// trigger pulses. Loads a clamped seconds value, counts to zero, pulses
// expired once, and drives BCD digits plus a warning/expired blink phase.
module vend_countdown #(
    parameter int MAX_SEC  = 99,
    parameter int WARN_SEC = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig_1Hz,
    input  logic       trig_2Hz,
    input  logic       start,
    input  logic       restart,
    input  logic       cancel,
    input  logic [6:0] load_sec,
    output logic       busy,
    output logic [6:0] remaining,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       expired,
    output logic       blink
);

    localparam logic [6:0] MAX_L  = 7'(MAX_SEC);
    localparam logic [6:0] WARN_L = 7'(WARN_SEC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXP} state_t;

    state_t     state_q, state_d;
    logic [6:0] rem_q, rem_d;
    logic       blink_q, blink_d;
    logic       exp_q, exp_d;
    logic [6:0] load_l;

    // Clamp the requested load to the display range.
    assign load_l = (load_sec > MAX_L) ? MAX_L : load_sec;

    // State, count, blink and expiry pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            blink_q <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            blink_q <= blink_d;
            exp_q   <= exp_d;
        end
    end

    // Next-state logic. Cancel wins everywhere; any path that lands on zero
    // funnels through the common expiry assignment at the bottom.
    always_comb begin
        logic expire;
        state_d = state_q;
        rem_d   = rem_q;
        blink_d = blink_q;
        exp_d   = 1'b0;
        expire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                blink_d = 1'b0;
                if (!cancel && start) begin
                    if (load_l != '0) begin
                        state_d = S_RUN;
                        rem_d   = load_l;
                    end else begin
                        expire = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                    blink_d = 1'b0;
                end else begin
                    // Blink window is judged on the pre-decrement count.
                    if (rem_q > WARN_L)
                        blink_d = 1'b0;
                    else if (trig_2Hz)
                        blink_d = ~blink_q;
                    // Restart shadows a coincident 1 Hz tick.
                    if (restart) begin
                        if (load_l != '0) rem_d = load_l;
                        else              expire = 1'b1;
                    end else if (trig_1Hz) begin
                        if (rem_q <= 7'd1) expire = 1'b1;
                        else               rem_d  = rem_q - 7'd1;
                    end
                end
            end
            S_EXP: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    blink_d = 1'b0;
                end else if (start) begin
                    if (load_l != '0) begin
                        state_d = S_RUN;
                        rem_d   = load_l;
                        blink_d = 1'b0;
                    end else begin
                        expire = 1'b1;
                    end
                end else if (trig_2Hz) begin
                    blink_d = ~blink_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
                blink_d = 1'b0;
            end
        endcase
        if (expire) begin
            state_d = S_EXP;
            rem_d   = '0;
            blink_d = 1'b1;
            exp_d   = 1'b1;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign remaining = rem_q;
    assign expired   = exp_q;
    assign blink     = blink_q;
    assign tens      = 4'(rem_q / 7'd10);
    assign ones      = 4'(rem_q % 7'd10);

endmodule
